// File: rtl/decode38_pkg.sv
// decode38_pkg: shared FSM state type and seven-segment constants for decode38_seq
package decode38_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [7:0] IDLE_SEG = 8'hFF;
  localparam logic [63:0] SEG_LUT = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  function automatic logic [7:0] seg_of(input logic [2:0] c);
    return SEG_LUT[{c, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/decode38_fifo.sv
// decode38_fifo: 3-bit wide FIFO with wrap-bit pointers; push on full and pop on empty are ignored
module decode38_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wp, r_rp;
  logic [2:0]  r_mem [DEPTH];
  logic        w_push, w_pop;
  assign empty  = r_wp == r_rp;
  assign full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rp[AW-1:0]];
  // pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
  // storage needs no reset; only slots behind the write pointer are ever read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/decode38_seq.sv
// decode38_seq: FIFO-fed 3-to-8 decoder holding each one-hot code HOLD_CYCLES clocks; define DECODE38_SEG_EN for seven-segment output seg
import decode38_pkg::*;
module decode38_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] x,
  input  logic       valid,
  output logic       in_ready,
  input  logic       en,
  output logic [7:0] y,
  output logic       indicate,
  output logic       busy
`ifdef DECODE38_SEG_EN
  ,
  output logic [7:0] seg
`endif
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_y;
  logic          r_ind;
  logic          w_full, w_empty, w_load;
  logic [2:0]    w_head;
  decode38_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (valid),
    .pop  (w_load),
    .din  (x),
    .dout (w_head),
    .full (w_full),
    .empty(w_empty)
  );
  assign w_load   = en && !w_empty && (r_state == IDLE || r_cnt == '0);
  assign in_ready = !w_full;
  assign busy     = (r_state == HOLD) || !w_empty;
  assign y        = r_y;
  assign indicate = r_ind;
  // load a new code back-to-back, count down the hold, or drop to idle on expiry or en low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_ind   <= 1'b0;
`ifdef DECODE38_SEG_EN
      seg     <= IDLE_SEG;
`endif
    end else if (w_load) begin
      r_state <= HOLD;
      r_cnt   <= RELOAD;
      r_y     <= 8'd1 << w_head;
      r_ind   <= 1'b1;
`ifdef DECODE38_SEG_EN
      seg     <= seg_of(w_head);
`endif
    end else if (r_state == HOLD && en && r_cnt != '0) begin
      r_cnt   <= r_cnt - 1'b1;
    end else begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_ind   <= 1'b0;
`ifdef DECODE38_SEG_EN
      seg     <= IDLE_SEG;
`endif
    end
  end
endmodule

// File: tb/tb_decode38_seq.sv
// tb_decode38_seq: queue-based reference model feeding a scoreboard checked once per cycle
module tb_decode38_seq;
  localparam int HOLD  = 4;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] x = '0;
  logic       valid = 1'b0;
  logic       en = 1'b0;
  logic       in_ready, indicate, busy;
  logic [7:0] y;
`ifdef DECODE38_SEG_EN
  logic [7:0] seg;
`endif
  typedef struct {
    logic [7:0] y;
    logic       ind;
    logic       rdy;
    logic       busy;
    logic [7:0] seg;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int mq[$];
  int cur = -1;
  int left = 0;
  logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
  decode38_seq #(.HOLD_CYCLES(HOLD), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .valid   (valid),
    .in_ready(in_ready),
    .en      (en),
    .y       (y),
    .indicate(indicate),
    .busy    (busy)
`ifdef DECODE38_SEG_EN
    ,
    .seg     (seg)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // reference model: the queue holds accepted codes, cur is the displayed code, left the cycles still owed
  always @(posedge clk or posedge rst) begin
    exp_t e;
    bit   was_full;
    if (rst) begin
      mq.delete();
      cur  = -1;
      left = 0;
    end else begin
      was_full = mq.size() == DEPTH;
      if (en && mq.size() > 0 && (cur < 0 || left == 0)) begin
        cur  = mq.pop_front();
        left = HOLD - 1;
      end else if (cur >= 0 && en && left > 0) begin
        left--;
      end else begin
        cur = -1;
      end
      if (valid && !was_full) mq.push_back(int'(x));
    end
    if (clk) begin
      e.y    = (cur < 0) ? 8'h00 : 8'(1 << cur);
      e.ind  = cur >= 0;
      e.rdy  = mq.size() < DEPTH;
      e.busy = (cur >= 0) || (mq.size() > 0);
      e.seg  = (cur < 0) ? 8'hFF : seg_tab[cur];
      sb.push_back(e);
    end
  end
  // monitor: each cycle the DUT presents one output state, compared to the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("y", 32'(y), 32'(e.y));
      chk("indicate", 32'(indicate), 32'(e.ind));
      chk("in_ready", 32'(in_ready), 32'(e.rdy));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("y_onehot0", 32'($onehot0(y)), 32'd1);
`ifdef DECODE38_SEG_EN
      chk("seg", 32'(seg), 32'(e.seg));
`endif
    end
  end
  task automatic step(input logic v, input logic [2:0] xx, input logic e);
    @(negedge clk);
    valid = v;
    x = xx;
    en = e;
  endtask
  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, e);
  endtask
  task automatic async_reset_check();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_indicate", 32'(indicate), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #1;
    chk("init_y", 32'(y), 32'h0);
    chk("init_in_ready", 32'(in_ready), 32'h1);
    chk("init_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b1);
    step(1'b1, 3'd5, 1'b1);
    idle(8, 1'b1);
    step(1'b1, 3'd0, 1'b1);
    step(1'b1, 3'd7, 1'b1);
    step(1'b1, 3'd3, 1'b1);
    idle(16, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 3'(i + 1), 1'b0);
    idle(3, 1'b0);
    idle(20, 1'b1);
    step(1'b1, 3'd2, 1'b1);
    step(1'b1, 3'd6, 1'b1);
    idle(1, 1'b1);
    idle(1, 1'b0);
    idle(2, 1'b0);
    idle(8, 1'b1);
    step(1'b1, 3'd4, 1'b1);
    step(1'b1, 3'd1, 1'b1);
    step(1'b1, 3'd2, 1'b1);
    idle(2, 1'b1);
    async_reset_check();
    idle(4, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) != 0));
      if (i == 700) async_reset_check();
    end
    idle(30, 1'b1);
    chk("queue_drained", 32'(sb.size() <= 1), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
